comma_aligner: RTL and testbench

- Symbol alignment stage directly upstream of the 8b/10b decoder in the PHY receive path.
- Takes raw 10-bit parallel words from the deserializer, which have arbitrary bit slip.
- Searches for K28.5 comma patterns and locks a bit offset with a hysteresis state machine.
- Emits symbol-aligned 10-bit words that drive the decoder's Data_in.

---
 rtl/comma_aligner_if.sv | 22 ++
 rtl/comma_aligner.sv | 129 ++++++++++++
 tb/tb_comma_aligner.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comma_aligner_if.sv
// Word-stream bundle between the deserializer, comma_aligner and the 8b/10b decoder.
// In_valid and Out_valid only qualify their data; there is no ready or backpressure.
interface comma_aligner_if;
  logic [9:0] Data_in;
  logic       In_valid;
  logic [9:0] Data_out;
  logic       Out_valid;
  logic       Aligned;
  logic       Comma_det;
  logic [3:0] Align_offset;
  logic [1:0] fsm_state;   // 0 = UNLOCKED, 1 = CHECK, 2 = LOCKED

  modport master (
    output Data_in, In_valid,
    input  Data_out, Out_valid, Aligned, Comma_det, Align_offset, fsm_state
  );

  modport slave (
    input  Data_in, In_valid,
    output Data_out, Out_valid, Aligned, Comma_det, Align_offset, fsm_state
  );
endinterface

// File: rtl/comma_aligner.sv
// Finds K28.5 commas in the raw deserializer stream and re-slices words onto the
// locked symbol boundary, using lock/loss hysteresis to ride through stray commas.
module comma_aligner #(
  parameter logic [9:0] COMMA_P  = 10'b0011111010,
  parameter logic [9:0] COMMA_N  = 10'b1100000101,
  parameter int         LOCK_CNT = 3,
  parameter int         LOSS_CNT = 4
) (
  input  logic           CLK,
  input  logic           Rst,
  comma_aligner_if.slave bus
);
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [4:0] LOCK_L = 5'(LOCK_CNT);
  localparam logic [4:0] LOSS_L = 5'(LOSS_CNT);
  // With a single-comma lock requirement a fresh offset is trusted immediately.
  localparam state_t RELOCK = (LOCK_CNT == 1) ? LOCKED : CHECK;

  state_t      state, state_n;
  logic [9:0]  prev;
  logic        prev_loaded;
  logic [3:0]  offset, offset_n;
  logic [3:0]  cnt, cnt_n;
  logic [3:0]  miss, miss_n;
  logic [19:0] win;
  logic        match;
  logic [3:0]  match_k;
  logic [9:0]  slice;

  assign win = {bus.Data_in, prev};

  // Descending scan so the lowest matching offset is the one that sticks.
  always_comb begin
    match   = 1'b0;
    match_k = '0;
    for (int k = 9; k >= 0; k--) begin
      if (win[k +: 10] == COMMA_P || win[k +: 10] == COMMA_N) begin
        match   = 1'b1;
        match_k = 4'(k);
      end
    end
  end

  always_comb begin
    state_n  = state;
    offset_n = offset;
    cnt_n    = cnt;
    miss_n   = miss;
    if (bus.In_valid && prev_loaded && match) begin
      case (state)
        UNLOCKED: begin
          offset_n = match_k;
          cnt_n    = 4'd1;
          miss_n   = '0;
          state_n  = RELOCK;
        end
        CHECK: begin
          if (match_k == offset) begin
            if ({1'b0, cnt} + 5'd1 == LOCK_L) begin
              state_n = LOCKED;
              cnt_n   = '0;
              miss_n  = '0;
            end else if (cnt != 4'hf) begin
              cnt_n = cnt + 4'd1;
            end
          end else begin
            offset_n = match_k;
            cnt_n    = 4'd1;
          end
        end
        LOCKED: begin
          if (match_k == offset) begin
            miss_n = '0;
          end else if ({1'b0, miss} + 5'd1 == LOSS_L) begin
            offset_n = match_k;
            cnt_n    = 4'd1;
            miss_n   = '0;
            state_n  = RELOCK;
          end else if (miss != 4'hf) begin
            miss_n = miss + 4'd1;
          end
        end
        default: state_n = UNLOCKED;
      endcase
    end
  end

  // Output slice uses the offset as updated this cycle, so a re-aligning comma
  // already appears symbol-aligned on Data_out.
  assign slice = 10'(win >> offset_n);

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state         <= UNLOCKED;
      prev          <= '0;
      prev_loaded   <= 1'b0;
      offset        <= '0;
      cnt           <= '0;
      miss          <= '0;
      bus.Data_out  <= '0;
      bus.Out_valid <= 1'b0;
      bus.Aligned   <= 1'b0;
      bus.Comma_det <= 1'b0;
    end else begin
      state       <= state_n;
      offset      <= offset_n;
      cnt         <= cnt_n;
      miss        <= miss_n;
      bus.Aligned <= (state_n == LOCKED);
      if (bus.In_valid) begin
        prev          <= bus.Data_in;
        prev_loaded   <= 1'b1;
        bus.Out_valid <= prev_loaded;
        bus.Data_out  <= slice;
        bus.Comma_det <= (slice == COMMA_P) || (slice == COMMA_N);
      end else begin
        bus.Out_valid <= 1'b0;
      end
    end
  end

  assign bus.Align_offset = offset;
  assign bus.fsm_state    = state;
endmodule

// File: tb/tb_comma_aligner.sv
// Bench for comma_aligner: a bit-level stream generator feeds words, and a
// bit-history reference model predicts every output cycle by cycle.
module tb_comma_aligner;
  localparam logic [9:0] COMMA_P  = 10'b0011111010;
  localparam logic [9:0] COMMA_N  = 10'b1100000101;
  localparam int         LOCK_CNT = 3;
  localparam int         LOSS_CNT = 4;

  logic CLK = 1'b0;
  logic Rst = 1'b1;

  comma_aligner_if bus ();

  comma_aligner #(
    .COMMA_P (COMMA_P),
    .COMMA_N (COMMA_N),
    .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT)
  ) dut (
    .CLK(CLK),
    .Rst(Rst),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  // Bit stream, first bit first; runs outside commas are kept short so that
  // commas only appear where they are deliberately placed.
  bit bitq[$];
  int total;
  bit last_bit;
  int run;

  // Reference model: last 20 received bits plus the alignment bookkeeping.
  bit         m_hist[$];
  bit         m_loaded;
  int         m_mode;   // 0 unlocked, 1 checking, 2 locked
  int         m_off, m_cnt, m_miss;
  logic [9:0] m_dout;
  bit         m_cdet, m_ov, m_al;

  function automatic bit is_comma(logic [9:0] v);
    return (v == COMMA_P) || (v == COMMA_N);
  endfunction

  function automatic logic [9:0] hist_word(int k);
    logic [9:0] v;
    v = '0;
    for (int j = 0; j < 10; j++) v[j] = m_hist[k + j];
    return v;
  endfunction

  task automatic model_clear();
    m_hist.delete();
    for (int j = 0; j < 10; j++) m_hist.push_back(1'b0);
    m_loaded = 0; m_mode = 0; m_off = 0; m_cnt = 0; m_miss = 0;
    m_dout = '0; m_cdet = 0; m_ov = 0; m_al = 0;
  endtask

  task automatic model_step(input bit r, input bit v, input logic [9:0] d);
    int mk;
    if (r) begin
      model_clear();
      return;
    end
    if (!v) begin
      m_ov = 0;
      return;
    end
    for (int j = 0; j < 10; j++) m_hist.push_back(d[j]);
    mk = -1;
    if (m_loaded)
      for (int k = 0; k < 10; k++)
        if (mk < 0 && is_comma(hist_word(k))) mk = k;
    if (mk >= 0) begin
      if (m_mode == 0) begin
        m_off = mk; m_cnt = 1; m_miss = 0;
        m_mode = (LOCK_CNT == 1) ? 2 : 1;
      end else if (m_mode == 1) begin
        if (mk == m_off) begin
          if (m_cnt + 1 == LOCK_CNT) begin
            m_mode = 2; m_cnt = 0; m_miss = 0;
          end else if (m_cnt < 15) begin
            m_cnt = m_cnt + 1;
          end
        end else begin
          m_off = mk; m_cnt = 1;
        end
      end else begin
        if (mk == m_off) begin
          m_miss = 0;
        end else if (m_miss + 1 == LOSS_CNT) begin
          m_off = mk; m_cnt = 1; m_miss = 0;
          m_mode = (LOCK_CNT == 1) ? 2 : 1;
        end else if (m_miss < 15) begin
          m_miss = m_miss + 1;
        end
      end
    end
    m_dout = hist_word(m_off);
    m_cdet = is_comma(m_dout);
    m_ov   = m_loaded;
    m_al   = (m_mode == 2);
    m_loaded = 1;
    for (int j = 0; j < 10; j++) void'(m_hist.pop_front());
  endtask

  function automatic logic [16:0] dut_vec();
    return {bus.Out_valid, bus.Data_out, bus.Comma_det, bus.Aligned, bus.Align_offset};
  endfunction

  function automatic logic [16:0] exp_vec();
    return {m_ov, m_dout, m_cdet, m_al, 4'(m_off)};
  endfunction

  // ---------------- drivers ----------------
  task automatic step(input bit v, input logic [9:0] d);
    bus.In_valid = v;
    bus.Data_in  = d;
    @(posedge CLK);
    model_step(Rst, v, d);
    if (m_ov) exp_q.push_back(m_dout);
    #1;
  endtask

  task automatic push_bit(input bit b);
    bitq.push_back(b);
    total++;
    if (run > 0 && b == last_bit) run++;
    else begin
      run = 1;
      last_bit = b;
    end
  endtask

  task automatic push_fill(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      if (run >= 2 && b == last_bit) b = ~b;
      push_bit(b);
    end
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic push_comma();
    logic [9:0] v;
    v = ($urandom_range(0, 1) == 1) ? COMMA_P : COMMA_N;
    for (int j = 0; j < 10; j++) push_bit(v[j]);
  endtask

  task automatic align_to(input int k);
    while (total % 10 != k) push_fill(1);
  endtask

  // Comma starting at stream phase k, followed by one data symbol so the
  // word completing the comma is emitted.
  task automatic comma_at(input int k);
    align_to(k);
    push_comma();
    push_fill(10);
  endtask

  task automatic emit_word();
    logic [9:0] w;
    for (int j = 0; j < 10; j++) w[j] = bitq.pop_front();
    step(1'b1, w);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    step(1'b0, '0);
    Rst = 1'b0;
    bitq.delete();
    total = 0;
    run = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 10'($urandom));
      checks++;
      if ({dut_vec(), bus.fsm_state} !== 19'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %h exp 0", c, {dut_vec(), bus.fsm_state});
      end
    end
    Rst = 1'b0;
    step(1'b1, 10'($urandom));
    checks++;
    if (bus.Out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_prime_word Out_valid got %b exp 0", bus.Out_valid);
    end
    step(1'b1, 10'($urandom));
    checks++;
    if (bus.Out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_second_word Out_valid got %b exp 1", bus.Out_valid);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_no_false_lock();
    do_reset();
    push_fill(2000);
    while (bitq.size() >= 10) begin
      emit_word();
      checks++;
      if (bus.Aligned !== 1'b0 || bus.fsm_state !== 2'd0 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL no_false_lock got %h st %0d exp %h st 0", dut_vec(), bus.fsm_state, exp_vec());
      end
    end
  endtask

  task automatic test_initial_lock();
    do_reset();
    align_to(3);
    for (int c = 1; c <= 5; c++) begin
      push_comma();
      push_fill(10);
      while (bitq.size() >= 10) begin
        emit_word();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL lock_model got %h exp %h", dut_vec(), exp_vec());
        end
      end
      checks++;
      if (bus.Align_offset !== 4'd3 || bus.Aligned !== (c >= 3) || bus.Comma_det !== 1'b1 ||
          (bus.Data_out !== COMMA_P && bus.Data_out !== COMMA_N)) begin
        errors++;
        $display("FAIL initial_lock comma %0d got off %0d al %b cd %b do %b exp off 3 al %b cd 1",
                 c, bus.Align_offset, bus.Aligned, bus.Comma_det, bus.Data_out, (c >= 3));
      end
    end
  endtask

  task automatic test_hysteresis();
    int   offs[10]   = '{7, 7, 7, 3, 7, 7, 7, 7, 7, 7};
    bit   exp_al[10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
    int   exp_of[10] = '{3, 3, 3, 3, 3, 3, 3, 7, 7, 7};
    for (int i = 0; i < 10; i++) begin
      comma_at(offs[i]);
      while (bitq.size() >= 10) begin
        emit_word();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL hyst_model got %h exp %h", dut_vec(), exp_vec());
        end
      end
      checks++;
      if (bus.Aligned !== exp_al[i] || bus.Align_offset !== 4'(exp_of[i])) begin
        errors++;
        $display("FAIL hysteresis step %0d got al %b off %0d exp al %b off %0d",
                 i, bus.Aligned, bus.Align_offset, exp_al[i], exp_of[i]);
      end
    end
  endtask

  task automatic test_valid_gaps();
    bit         pat[4] = '{1, 0, 0, 1};
    logic [9:0] held;
    comma_at(7);
    push_fill(60);
    for (int rep = 0; rep < 3; rep++) begin
      for (int p = 0; p < 4; p++) begin
        held = bus.Data_out;
        if (pat[p]) emit_word();
        else step(1'b0, 10'($urandom));
        checks++;
        if (bus.Out_valid !== pat[p] || (!pat[p] && bus.Data_out !== held) ||
            bus.Aligned !== 1'b1 || bus.Align_offset !== 4'd7 || dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL valid_gap rep %0d slot %0d got %h exp %h held %b",
                   rep, p, dut_vec(), exp_vec(), held);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    checks++;
    if (bus.Aligned !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_precondition Aligned got %b exp 1", bus.Aligned);
    end
    Rst = 1'b1;
    step(1'b1, 10'($urandom));
    Rst = 1'b0;
    checks++;
    if (bus.Aligned !== 1'b0 || bus.Align_offset !== 4'd0 || bus.Out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop got al %b off %0d ov %b exp 0 0 0",
               bus.Aligned, bus.Align_offset, bus.Out_valid);
    end
    bitq.delete();
    total = 0;
    run = 0;
    for (int c = 1; c <= LOCK_CNT; c++) begin
      comma_at(3);
      while (bitq.size() >= 10) begin
        emit_word();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL relock_model got %h exp %h", dut_vec(), exp_vec());
        end
      end
      checks++;
      if (bus.Aligned !== (c == LOCK_CNT) || bus.Align_offset !== 4'd3) begin
        errors++;
        $display("FAIL mid_reset_relock comma %0d got al %b off %0d exp al %b off 3",
                 c, bus.Aligned, bus.Align_offset, (c == LOCK_CNT));
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] exp_d;
    do_reset();
    exp_q.delete();
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0:       push_comma();
        1:       push_fill($urandom_range(1, 9));
        2:       push_fill(10);
        default: push_rand(10);
      endcase
      while (bitq.size() >= 10) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 10'($urandom));
        else emit_word();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random_model iter %0d got %h exp %h", it, dut_vec(), exp_vec());
        end
        if (bus.Out_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL random_scoreboard unexpected output got %b exp none", bus.Data_out);
          end else begin
            exp_d = exp_q.pop_front();
            if (bus.Data_out !== exp_d) begin
              errors++;
              $display("FAIL random_scoreboard got %b exp %b", bus.Data_out, exp_d);
            end
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_scoreboard_drain got %0d left exp 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.In_valid = 1'b0;
    bus.Data_in  = '0;
    total = 0;
    run = 0;
    model_clear();
    test_reset();
    test_no_false_lock();
    test_initial_lock();
    test_hysteresis();
    test_valid_gaps();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
